writeback_unit: RTL and testbench
=================================

# writeback_unit

Write-side owner of the 32x32 register file's single write port. It merges single-cycle ALU results with variable-latency load returns from the data memory path and drives `rd`/`datawb`/`regwren` into the register file through one registered stage. It also keeps a pending-load scoreboard so decode can stall on read-after-write hazards against loads still in flight.

## Interface
- `DWIDTH`, 32, data width of write-back values.
- `DEPTH`, 4, load-return FIFO depth; power of two, at least 2.

- `clk`  in  1  single clock, all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid_i`  in  1  ALU result present this cycle; no backpressure.
- `alu_rd_i`  in  5  ALU destination register.
- `alu_data_i`  in  DWIDTH  ALU result.
- `ld_valid_i`  in  1  load return offered.
- `ld_rd_i`  in  5  load destination register.
- `ld_data_i`  in  DWIDTH  load data, already sign/zero-extended.
- `ld_ready_o`  out  1  FIFO can accept; equals `!full`.
- `issue_valid_i`  in  1  a load is issued this cycle.
- `issue_rd_i`  in  5  destination of the issued load.
- `rs1_i`, `rs2_i`  in  5 each  decode source registers.
- `rs1_busy_o`, `rs2_busy_o`  out  1 each  combinational; the source register has a pending load.
- `fifo_full_o`  out  1  FIFO full; the pipeline must insert an ALU bubble.
- `rd_o`  out  5  registered; goes to the register file `rd_i`.
- `datawb_o`  out  DWIDTH  registered; goes to the register file `datawb_i`.
- `regwren_o`  out  1  registered; goes to the register file `regwren_i`.

## Operation
- **Load FIFO**
  - Push when `ld_valid_i && ld_ready_o`.
  - Entries hold {rd, data}, DEPTH entries deep.
  - Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full/empty come from the MSB compare.
  - No push while full, even in a cycle that also pops.
- **Arbitration (each cycle)**
  - If `alu_valid_i`, select the ALU result.
  - Otherwise, if the FIFO is not empty, pop the head and select it.
  - Otherwise select nothing.
  - The ALU always wins. Starvation is avoided by the pipeline honouring `fifo_full_o`.
- **Write-back register**
  - On each edge, load `rd_o`/`datawb_o` from the selected source.
  - Set `regwren_o` = selected && rd != 0.
  - An rd=0 load entry is still popped but produces `regwren_o`=0.
  - With no selection, `regwren_o`=0 and `rd_o`/`datawb_o` hold their previous values.
  - A flag `wb_is_load` is registered alongside these outputs.
- **Scoreboard (32 bits, bit 0 constant 0)**
  - Set bit `issue_rd_i` when `issue_valid_i` and rd != 0.
  - Clear bit `rd_o` on the edge where `regwren_o && wb_is_load`. This is the same edge on which the register file captures the data.
  - If a set and a clear target the same bit on the same edge, the set wins.
  - Issuing to an already-pending rd leaves the bit set; it clears on the first matching load write. Avoiding this is the caller's responsibility.
  - ALU writes never touch the scoreboard.
- **Busy outputs**
  - `rsN_busy_o` = scoreboard[rsN_i]; always 0 for x0.
  - Busy stays high through the cycle in which `regwren_o` presents the load. It drops in the next cycle, when the register file holds the new value.

## Timing
- **Reset** (takes effect at the next edge with `rst`=1; overrides every other event in that cycle):
  - FIFO empty, pointers 0.
  - Scoreboard all 0.
  - `regwren_o`=0, `rd_o`=0, `datawb_o`=0, `wb_is_load`=0.
- **Outputs after reset:** `ld_ready_o`=1, `fifo_full_o`=0, busy outputs 0.
- **Reset mid-operation:** queued loads and pending bits are discarded, and no write-back is emitted in the cycle after reset.
- **Latency:**
  - ALU result: presented in cycle N, `regwren_o` in N+1.
  - Load return: pushed in cycle N, earliest `regwren_o` in N+2, because the push lands at edge N and the pop is selected in N+1.
- **Throughput:** one register-file write per cycle maximum.
- **Simultaneous push and pop on a non-full FIFO:** both occur, so the occupancy is unchanged.
- **`ld_ready_o` and `fifo_full_o`:** combinational from the pointers only; they do not depend on `ld_valid_i`.

## Test plan
- **Reset:** assert `rst` with 3 loads queued and x5 pending. Required: one cycle later `regwren_o`=0, `ld_ready_o`=1, `rs1_busy_o`=0 for `rs1_i`=5.
- **ALU path:** `alu_valid_i`=1, rd=7, data=0xDEADBEEF in cycle N. Required: `regwren_o`=1, `rd_o`=7, `datawb_o`=0xDEADBEEF in N+1; with rd=0, `regwren_o`=0.
- **Load and scoreboard:**
  - Issue rd=9 in cycle N; required: `rs2_busy_o`=1 from N+1.
  - Return 0x1234 in M; required: `regwren_o`=1 in M+2, busy still 1 in M+2, busy 0 in M+3.
- **Priority and fill:**
  - Hold `alu_valid_i` high while pushing 4 loads. Required: `fifo_full_o`=1 and `ld_ready_o`=0 after the 4th push; a 5th offered load is not accepted.
  - Drop `alu_valid_i`. Required: the 4 loads write back in FIFO order on consecutive cycles.
- **Set/clear collision:** a load to x3 writes back (`regwren_o`=1, `rd_o`=3) in the same cycle a new load to x3 is issued. Required: x3 busy stays 1 afterward.
- **Pointer wrap:** stream 3*DEPTH loads with random rd and ALU gaps. Required: every write matches a reference queue in order, with no loss or duplication across the wrap.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU results (priority) and queued load returns into one registered register-file write port; ports: alu_*/ld_* sources, issue_*/rs*_busy scoreboard, rd_o/datawb_o/regwren_o write-back
module writeback_unit #(
  parameter int DWIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_i,
  input  logic [4:0]        alu_rd_i,
  input  logic [DWIDTH-1:0] alu_data_i,
  input  logic              ld_valid_i,
  input  logic [4:0]        ld_rd_i,
  input  logic [DWIDTH-1:0] ld_data_i,
  output logic              ld_ready_o,
  input  logic              issue_valid_i,
  input  logic [4:0]        issue_rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              fifo_full_o,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]        fifo_rd   [DEPTH];
  logic [DWIDTH-1:0] fifo_data [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic [31:0]       sb, set_mask, clr_mask;
  logic              wb_is_load, empty, full, push, pop, sel;
  logic [4:0]        sel_rd;
  logic [DWIDTH-1:0] sel_data;
  always_comb begin
    empty    = wptr == rptr;
    full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    push     = ld_valid_i && !full;
    pop      = !alu_valid_i && !empty;
    sel      = alu_valid_i || pop;
    sel_rd   = alu_valid_i ? alu_rd_i : fifo_rd[rptr[AW-1:0]];
    sel_data = alu_valid_i ? alu_data_i : fifo_data[rptr[AW-1:0]];
    set_mask = (issue_valid_i && issue_rd_i != 5'd0) ? 32'd1 << issue_rd_i : 32'd0;
    clr_mask = (regwren_o && wb_is_load) ? 32'd1 << rd_o : 32'd0;
  end
  assign ld_ready_o  = !full;
  assign fifo_full_o = full;
  assign rs1_busy_o  = sb[rs1_i];
  assign rs2_busy_o  = sb[rs2_i];
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_rd[wptr[AW-1:0]]   <= ld_rd_i;
      fifo_data[wptr[AW-1:0]] <= ld_data_i;
    end
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      sb         <= '0;
      regwren_o  <= 1'b0;
      rd_o       <= '0;
      datawb_o   <= '0;
      wb_is_load <= 1'b0;
    end else begin
      wptr       <= wptr + (AW+1)'(push);
      rptr       <= rptr + (AW+1)'(pop);
      sb         <= (sb & ~clr_mask) | set_mask;
      regwren_o  <= sel && sel_rd != 5'd0;
      wb_is_load <= pop;
      if (sel) begin
        rd_o     <= sel_rd;
        datawb_o <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: vector table, directed corner sequences and random streaming against a queue-based reference model
module tb_writeback_unit;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, alu_valid_i, ld_valid_i, issue_valid_i, ld_ready_o, rs1_busy_o, rs2_busy_o, fifo_full_o, regwren_o;
  logic [4:0] alu_rd_i, ld_rd_i, issue_rd_i, rs1_i, rs2_i, rd_o;
  logic [DW-1:0] alu_data_i, ld_data_i, datawb_o;
  always #5 clk = ~clk;
  writeback_unit #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .fifo_full_o(fifo_full_o), .rd_o(rd_o), .datawb_o(datawb_o), .regwren_o(regwren_o)
  );
  int checks = 0;
  int fails = 0;
  logic [4:0] mq_rd[$];
  logic [DW-1:0] mq_data[$];
  bit pend[32];
  bit m_wren, m_isld, last_acc;
  logic [4:0] m_rd;
  logic [DW-1:0] m_data;
  typedef struct {
    bit av;
    logic [4:0] rd;
    logic [DW-1:0] d;
    bit ew;
    logic [4:0] erd;
    logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic idle();
    rst = 0; alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    ld_valid_i = 0; ld_rd_i = 0; ld_data_i = 0; issue_valid_i = 0; issue_rd_i = 0;
  endtask
  task automatic cycle();
    logic [4:0] r;
    logic [DW-1:0] d;
    #1;
    chk("ld_ready", ld_ready_o, mq_rd.size() < DEPTH);
    chk("fifo_full", fifo_full_o, mq_rd.size() == DEPTH);
    chk("rs1_busy", rs1_busy_o, pend[rs1_i]);
    chk("rs2_busy", rs2_busy_o, pend[rs2_i]);
    last_acc = 0;
    if (rst) begin
      mq_rd.delete(); mq_data.delete();
      foreach (pend[i]) pend[i] = 0;
      m_wren = 0; m_isld = 0; m_rd = 0; m_data = 0;
    end else begin
      last_acc = ld_valid_i && mq_rd.size() < DEPTH;
      if (m_wren && m_isld) pend[m_rd] = 0;
      if (issue_valid_i && issue_rd_i != 0) pend[issue_rd_i] = 1;
      if (alu_valid_i) begin
        m_rd = alu_rd_i; m_data = alu_data_i; m_wren = alu_rd_i != 0; m_isld = 0;
      end else if (mq_rd.size() > 0) begin
        r = mq_rd.pop_front(); d = mq_data.pop_front();
        m_rd = r; m_data = d; m_wren = r != 0; m_isld = 1;
      end else begin
        m_wren = 0; m_isld = 0;
      end
      if (last_acc) begin
        mq_rd.push_back(ld_rd_i); mq_data.push_back(ld_data_i);
      end
    end
    @(posedge clk);
    #1;
    chk("regwren", regwren_o, m_wren);
    chk("rd", rd_o, m_rd);
    chk("datawb", datawb_o, m_data);
  endtask
  initial begin
    int pushed, budget;
    tbl[0] = '{1, 5'd7,  32'hDEADBEEF, 1, 5'd7,  32'hDEADBEEF};
    tbl[1] = '{1, 5'd0,  32'h00001111, 0, 5'd0,  32'h00001111};
    tbl[2] = '{0, 5'd9,  32'h22222222, 0, 5'd0,  32'h00001111};
    tbl[3] = '{1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 32'hFFFFFFFF};
    tbl[4] = '{1, 5'd1,  32'h00000000, 1, 5'd1,  32'h00000000};
    tbl[5] = '{0, 5'd5,  32'h000000AA, 0, 5'd1,  32'h00000000};
    idle(); rs1_i = 0; rs2_i = 0;
    m_wren = 0; m_isld = 0; m_rd = 0; m_data = 0;
    @(posedge clk); #1;
    rst = 1; cycle(); cycle();
    idle();
    chk("rst_regwren", regwren_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_data", datawb_o, 0);
    #1 chk("rst_ready", ld_ready_o, 1);
    chk("rst_full", fifo_full_o, 0);
    foreach (tbl[i]) begin
      idle();
      alu_valid_i = tbl[i].av; alu_rd_i = tbl[i].rd; alu_data_i = tbl[i].d;
      cycle();
      chk("vec_wren", regwren_o, tbl[i].ew);
      chk("vec_rd", rd_o, tbl[i].erd);
      chk("vec_data", datawb_o, tbl[i].ed);
    end
    for (int i = 0; i < 3; i++) begin
      idle(); alu_valid_i = 1; alu_rd_i = 2; alu_data_i = i;
      ld_valid_i = 1; ld_rd_i = 5'(20 + i); ld_data_i = 32'(i);
      issue_valid_i = (i == 0); issue_rd_i = 5;
      cycle();
    end
    idle(); rs1_i = 5; rst = 1; cycle();
    idle();
    chk("rstmid_wren", regwren_o, 0);
    #1 chk("rstmid_ready", ld_ready_o, 1);
    chk("rstmid_busy", rs1_busy_o, 0);
    cycle();
    chk("rstmid_nowb", regwren_o, 0);
    idle(); issue_valid_i = 1; issue_rd_i = 9; cycle();
    idle(); rs2_i = 9;
    #1 chk("issue_busy", rs2_busy_o, 1);
    ld_valid_i = 1; ld_rd_i = 9; ld_data_i = 32'h1234; cycle();
    idle(); cycle();
    chk("ld_wren", regwren_o, 1);
    chk("ld_rd", rd_o, 9);
    chk("ld_data", datawb_o, 32'h1234);
    #1 chk("ld_busy_hold", rs2_busy_o, 1);
    cycle();
    chk("ld_busy_drop", rs2_busy_o, 0);
    for (int i = 0; i < 5; i++) begin
      idle(); alu_valid_i = 1; alu_rd_i = 4; alu_data_i = 32'(50 + i);
      ld_valid_i = 1; ld_rd_i = 5'(10 + i); ld_data_i = 32'(100 + i);
      cycle();
      if (i == 3) begin
        chk("fill_full", fifo_full_o, 1);
        chk("fill_ready", ld_ready_o, 0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      idle(); cycle();
      chk("drain_wren", regwren_o, i < 4);
      if (i < 4) begin
        chk("drain_rd", rd_o, 10 + i);
        chk("drain_data", datawb_o, 100 + i);
      end
    end
    idle(); issue_valid_i = 1; issue_rd_i = 3; cycle();
    idle(); ld_valid_i = 1; ld_rd_i = 3; ld_data_i = 32'h33; cycle();
    idle(); cycle();
    chk("coll_wb", {regwren_o, rd_o}, {1'b1, 5'd3});
    idle(); issue_valid_i = 1; issue_rd_i = 3; rs1_i = 3; cycle();
    chk("coll_busy", rs1_busy_o, 1);
    idle(); cycle();
    chk("coll_busy2", rs1_busy_o, 1);
    pushed = 0; budget = 0;
    while (pushed < 3 * DEPTH && budget < 2000) begin
      idle();
      alu_valid_i = ($urandom_range(0, 9) < 3); alu_rd_i = 5'($urandom); alu_data_i = $urandom;
      ld_valid_i = ($urandom_range(0, 9) < 6); ld_rd_i = 5'($urandom); ld_data_i = $urandom;
      issue_valid_i = $urandom_range(0, 1); issue_rd_i = 5'($urandom);
      rs1_i = 5'($urandom); rs2_i = 5'($urandom);
      cycle();
      if (last_acc) pushed++;
      budget++;
    end
    chk("wrap_pushed", pushed >= 3 * DEPTH, 1);
    budget = 0;
    while (mq_rd.size() > 0 && budget < 50) begin
      idle(); cycle(); budget++;
    end
    chk("wrap_drained", mq_rd.size(), 0);
    idle(); cycle();
    chk("wrap_idle_wren", regwren_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
